osc_monitor: RTL and testbench

// Read-back end of the oscillator sample stream: consumes the 12-bit offset-binary

---
 rtl/dds_pkg.sv | 19 +
 rtl/osc_xdet.sv | 23 ++
 rtl/osc_monitor.sv | 147 ++++++++++++++
 tb/tb_osc_monitor.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared DDS sample width, monitor state type and mid-scale helper
package dds_pkg;

  localparam int DDS_DW = 12;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEEK_LOW  = 3'd1,
    SEEK_RISE = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } osc_state_e;

  // Offset-binary mid-scale code for a dw-bit sample.
  function automatic int mid_code(input int dw);
    return 1 << (dw - 1);
  endfunction

endpackage

// File: rtl/osc_xdet.sv
// rtl/osc_xdet.sv - classifies a sample as low or high with hysteresis about mid-scale
module osc_xdet
  import dds_pkg::*;
#(
  parameter int DW   = DDS_DW,
  parameter int HYST = 64
) (
  input  logic [DW-1:0] sample,
  output logic          is_lo,
  output logic          is_hi
);

  localparam int MID = mid_code(DW);
  // One extra bit so a threshold above full-scale simply never matches.
  localparam logic [DW:0] LO_TH = (DW+1)'(MID - HYST);
  localparam logic [DW:0] HI_TH = (DW+1)'(MID + HYST);

  always_comb begin
    is_lo = ({1'b0, sample} <= LO_TH);
    is_hi = ({1'b0, sample} >= HI_TH);
  end

endmodule

// File: rtl/osc_monitor.sv
// rtl/osc_monitor.sv - measures one waveform period and its peaks from the DAC sample stream
module osc_monitor
  import dds_pkg::*;
#(
  parameter int DW          = DDS_DW,
  parameter int CW          = 20,
  parameter int HYST        = 64,
  parameter int TIMEOUT_SMP = 1000000
) (
  input  logic          Fg_clk,
  input  logic          Resetn,
  input  logic [DW-1:0] Sample_in,
  input  logic          Sample_vld,
  input  logic          Start,
  input  logic          Abort,
  output logic          Busy,
  output logic          Meas_vld,
  output logic [CW-1:0] Period,
  output logic [DW-1:0] Peak_max,
  output logic [DW-1:0] Peak_min,
  output logic          Timeout
);

  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_SMP - 1);

  osc_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wd_q, wd_d;
  logic [CW-1:0] period_q, period_d;
  logic [DW-1:0] max_q, max_d;
  logic [DW-1:0] min_q, min_d;
  logic [DW-1:0] pmax_q, pmax_d;
  logic [DW-1:0] pmin_q, pmin_d;
  logic          armed_q, armed_d;
  logic          tout_q, tout_d;
  logic          s_lo, s_hi;
  logic          second_xing;

  osc_xdet #(
    .DW   (DW),
    .HYST (HYST)
  ) u_xdet (
    .sample (Sample_in),
    .is_lo  (s_lo),
    .is_hi  (s_hi)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    period_d    = period_q;
    max_d       = max_q;
    min_d       = min_q;
    pmax_d      = pmax_q;
    pmin_d      = pmin_q;
    armed_d     = armed_q;
    tout_d      = tout_q;
    second_xing = 1'b0;

    if (Abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            state_d = SEEK_LOW;
            wd_d    = '0;
          end
        end
        DONE: state_d = IDLE;
        default: begin
          if (Sample_vld) begin
            wd_d = wd_q + 1'b1;
            if (state_q == SEEK_LOW && s_lo) begin
              state_d = SEEK_RISE;
            end
            if (state_q == SEEK_RISE && s_hi) begin
              state_d = MEASURE;
              cnt_d   = '0;
              max_d   = Sample_in;
              min_d   = Sample_in;
              armed_d = 1'b0;
            end
            if (state_q == MEASURE) begin
              cnt_d = cnt_q + 1'b1;
              max_d = (Sample_in > max_q) ? Sample_in : max_q;
              min_d = (Sample_in < min_q) ? Sample_in : min_q;
              if (s_lo) armed_d = 1'b1;
              second_xing = s_hi && armed_q;
            end
            // A completed period on the last allowed sample still counts as valid.
            if (second_xing) begin
              state_d  = DONE;
              period_d = cnt_q + 1'b1;
              pmax_d   = max_d;
              pmin_d   = min_d;
              tout_d   = 1'b0;
            end else if (wd_q >= WD_LAST) begin
              state_d  = DONE;
              period_d = '1;
              pmax_d   = '0;
              pmin_d   = '1;
              tout_d   = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wd_q     <= '0;
      period_q <= '0;
      max_q    <= '0;
      min_q    <= '0;
      pmax_q   <= '0;
      pmin_q   <= '0;
      armed_q  <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      period_q <= period_d;
      max_q    <= max_d;
      min_q    <= min_d;
      pmax_q   <= pmax_d;
      pmin_q   <= pmin_d;
      armed_q  <= armed_d;
      tout_q   <= tout_d;
    end
  end

  always_comb begin
    Busy     = (state_q != IDLE);
    Meas_vld = (state_q == DONE);
    Period   = period_q;
    Peak_max = pmax_q;
    Peak_min = pmin_q;
    Timeout  = tout_q;
  end

endmodule

// File: tb/tb_osc_monitor.sv
// tb/tb_osc_monitor.sv - randomized scoreboard bench for osc_monitor
module tb_osc_monitor;

  localparam int TO = 500;

  typedef struct packed {
    logic [19:0] period;
    logic [11:0] pmax;
    logic [11:0] pmin;
    logic        tout;
  } res_t;

  logic        Fg_clk = 1'b0;
  logic        Resetn = 1'b0;
  logic [11:0] Sample_in = '0;
  logic        Sample_vld = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic        Busy, Meas_vld, Timeout;
  logic [19:0] Period;
  logic [11:0] Peak_max, Peak_min;

  int          n_vec = 0;
  int          n_mis = 0;
  int          meas_cnt = 0;
  res_t        exp_q[$];
  res_t        last_res = '0;
  logic [11:0] stim[$];

  osc_monitor #(
    .DW          (12),
    .CW          (20),
    .HYST        (64),
    .TIMEOUT_SMP (TO)
  ) dut (
    .Fg_clk     (Fg_clk),
    .Resetn     (Resetn),
    .Sample_in  (Sample_in),
    .Sample_vld (Sample_vld),
    .Start      (Start),
    .Abort      (Abort),
    .Busy       (Busy),
    .Meas_vld   (Meas_vld),
    .Period     (Period),
    .Peak_max   (Peak_max),
    .Peak_min   (Peak_min),
    .Timeout    (Timeout)
  );

  always #5 Fg_clk = ~Fg_clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic bit is_lo(input logic [11:0] s);
    return int'(s) <= 2048 - 64;
  endfunction

  function automatic bit is_hi(input logic [11:0] s);
    return int'(s) >= 2048 + 64;
  endfunction

  // Reference: find low, rising crossing, low, next rising crossing in the post-Start sample list.
  function automatic void model(output res_t r, output int n);
    int i0 = -1, i1 = -1, i2 = -1, i3 = -1;
    logic [11:0] mx, mn;
    for (int i = 0; i < TO; i++) begin
      if (i0 < 0) begin
        if (is_lo(stim[i])) i0 = i;
      end else if (i1 < 0) begin
        if (is_hi(stim[i])) i1 = i;
      end else if (i2 < 0) begin
        if (is_lo(stim[i])) i2 = i;
      end else if (is_hi(stim[i])) begin
        i3 = i;
        break;
      end
    end
    if (i3 >= 0) begin
      mx = stim[i1];
      mn = stim[i1];
      for (int i = i1; i <= i3; i++) begin
        if (stim[i] > mx) mx = stim[i];
        if (stim[i] < mn) mn = stim[i];
      end
      r.period = 20'(i3 - i1);
      r.pmax   = mx;
      r.pmin   = mn;
      r.tout   = 1'b0;
      n        = i3 + 1;
    end else begin
      r.period = 20'hFFFFF;
      r.pmax   = 12'h000;
      r.pmin   = 12'hFFF;
      r.tout   = 1'b1;
      n        = TO;
    end
  endfunction

  always @(negedge Fg_clk) begin
    if (Resetn && Meas_vld) begin
      res_t r;
      meas_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_meas_vld", 32'd1, 32'd0);
      end else begin
        r = exp_q.pop_front();
        check("period", 32'(Period), 32'(r.period));
        check("peak_max", 32'(Peak_max), 32'(r.pmax));
        check("peak_min", 32'(Peak_min), 32'(r.pmin));
        check("timeout", 32'(Timeout), 32'(r.tout));
      end
    end
  end

  task automatic fill_square(input int hv, input int lv, input int h, input int l, input int ph);
    stim.delete();
    for (int i = 0; i < TO; i++) stim.push_back(((i + ph) % (h + l)) < h ? 12'(hv) : 12'(lv));
  endtask

  task automatic fill_sine(input real amp, input int per, input int ph);
    stim.delete();
    for (int i = 0; i < TO; i++)
      stim.push_back(12'($rtoi(2048.0 + amp * $sin(2.0 * 3.14159265358979 * ((i + ph) % per) / per) + 0.5)));
  endtask

  task automatic fill_toggle(input int a, input int b);
    stim.delete();
    for (int i = 0; i < TO; i++) stim.push_back((i % 2) ? 12'(a) : 12'(b));
  endtask

  task automatic fill_noise();
    stim.delete();
    for (int i = 0; i < TO; i++) stim.push_back(12'($urandom));
  endtask

  task automatic feed(input int first, input int last, input int gmin, input int gmax, input bit spam);
    for (int i = first; i < last; i++) begin
      repeat ($urandom_range(gmin, gmax)) begin
        Sample_in = 12'($urandom);
        Start     = spam && ($urandom_range(0, 3) == 0);
        @(posedge Fg_clk); #1;
      end
      Sample_in  = stim[i];
      Sample_vld = 1'b1;
      Start      = spam && ($urandom_range(0, 3) == 0);
      @(posedge Fg_clk); #1;
      Sample_vld = 1'b0;
      Start      = 1'b0;
      Sample_in  = 12'($urandom);
    end
  endtask

  task automatic run_meas(input int gmin, input int gmax, input bit spam, input bit start_in_done);
    res_t r;
    int   n;
    int   m0;
    model(r, n);
    exp_q.push_back(r);
    m0    = meas_cnt;
    Start = 1'b1;
    @(posedge Fg_clk); #1;
    Start = 1'b0;
    check("busy_after_start", 32'(Busy), 32'd1);
    feed(0, n - 1, gmin, gmax, spam);
    check("busy_before_last", 32'(Busy), 32'd1);
    feed(n - 1, n, gmin, gmax, spam);
    if (start_in_done) Start = 1'b1;
    @(posedge Fg_clk); #1;
    Start = 1'b0;
    check("idle_after_done", 32'(Busy), 32'd0);
    repeat (3) @(posedge Fg_clk);
    #1;
    check("meas_count", 32'(meas_cnt - m0), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    last_res = r;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    res_t r;
    int   n;
    int   m0;

    repeat (2) @(posedge Fg_clk);
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_meas_vld", 32'(Meas_vld), 32'd0);
    check("rst_period", 32'(Period), 32'd0);
    check("rst_peak_max", 32'(Peak_max), 32'd0);
    check("rst_peak_min", 32'(Peak_min), 32'd0);
    check("rst_timeout", 32'(Timeout), 32'd0);
    Resetn = 1'b1;
    @(posedge Fg_clk); #1;

    fill_square(4095, 0, 50, 50, 0);
    run_meas(0, 0, 1'b0, 1'b0);

    fill_sine(1000.0, 37, int'($urandom_range(0, 36)));
    run_meas(3, 3, 1'b0, 1'b0);

    fill_toggle(2048, 2048);
    run_meas(0, 1, 1'b0, 1'b0);

    fill_toggle(2048 + 63, 2048 - 63);
    run_meas(0, 0, 1'b0, 1'b0);

    fill_square(3500, 500, 20, 25, int'($urandom_range(0, 44)));
    run_meas(0, 3, 1'b1, 1'b1);

    // Abort together with Start while measuring: back to idle, previous result kept.
    fill_square(4000, 100, 30, 30, int'($urandom_range(0, 59)));
    model(r, n);
    m0    = meas_cnt;
    Start = 1'b1;
    @(posedge Fg_clk); #1;
    Start = 1'b0;
    feed(0, n - 5, 0, 2, 1'b0);
    Abort = 1'b1;
    Start = 1'b1;
    @(posedge Fg_clk); #1;
    Abort = 1'b0;
    Start = 1'b0;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_period_kept", 32'(Period), 32'(last_res.period));
    check("abort_max_kept", 32'(Peak_max), 32'(last_res.pmax));
    check("abort_min_kept", 32'(Peak_min), 32'(last_res.pmin));
    check("abort_tout_kept", 32'(Timeout), 32'(last_res.tout));
    repeat (5) @(posedge Fg_clk);
    #1;
    check("abort_no_meas", 32'(meas_cnt - m0), 32'd0);

    for (int k = 0; k < 6; k++) begin
      if (k % 3 == 0) fill_noise();
      else fill_square(int'($urandom_range(2112, 4095)), int'($urandom_range(0, 1984)),
                       int'($urandom_range(3, 60)), int'($urandom_range(3, 60)),
                       int'($urandom_range(0, 200)));
      run_meas(0, int'($urandom_range(0, 3)), 1'(k % 2), 1'(k % 2));
    end

    // Asynchronous reset in the middle of a measurement.
    fill_square(4095, 0, 50, 50, 0);
    Start = 1'b1;
    @(posedge Fg_clk); #1;
    Start = 1'b0;
    feed(0, 120, 0, 0, 1'b0);
    #2;
    Resetn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_period", 32'(Period), 32'd0);
    check("mid_rst_peak_max", 32'(Peak_max), 32'd0);
    check("mid_rst_peak_min", 32'(Peak_min), 32'd0);
    check("mid_rst_timeout", 32'(Timeout), 32'd0);
    @(posedge Fg_clk); #1;
    Resetn = 1'b1;
    repeat (2) @(posedge Fg_clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
